// File: rtl/factor_pkg.sv
// Shared definitions for the factor game: state codes, exponent table, prime-select codes.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Used by factor_game_ctrl, factor_qrom and the 7-segment display decoder.
package factor_pkg;

  // State codes double as the display decoder's input, so they are fixed values.
  typedef enum logic [3:0] {
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_WRONG    = 4'b0111,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011
  } state_t;

  // Remaining prime exponents of the current question.
  typedef struct packed {
    logic [1:0] e2;
    logic [1:0] e3;
    logic [1:0] e5;
    logic [1:0] e7;
  } exps_t;

  // Prime selection codes carried on DIN.
  localparam logic [3:0] DIN_NONE = 4'd0;
  localparam logic [3:0] DIN_P2   = 4'd1;
  localparam logic [3:0] DIN_P3   = 4'd2;
  localparam logic [3:0] DIN_P5   = 4'd3;
  localparam logic [3:0] DIN_P7   = 4'd4;

  localparam int NUM_Q = 10;

  // Question table: {e2,e3,e5,e7} per question index.
  localparam exps_t Q_TABLE [NUM_Q] = '{
    exps_t'(8'h90),  // 0:  12 = 2^2*3
    exps_t'(8'h60),  // 1:  18 = 2*3^2
    exps_t'(8'h54),  // 2:  30 = 2*3*5
    exps_t'(8'h51),  // 3:  42 = 2*3*7
    exps_t'(8'h94),  // 4:  60 = 2^2*3*5
    exps_t'(8'h45),  // 5:  70 = 2*5*7
    exps_t'(8'h91),  // 6:  84 = 2^2*3*7
    exps_t'(8'h64),  // 7:  90 = 2*3^2*5
    exps_t'(8'h15),  // 8: 105 = 3*5*7
    exps_t'(8'h61)   // 9: 126 = 2*3^2*7
  };

  // Exponent of the prime selected by din; zero for any non-prime code.
  function automatic logic [1:0] exp_of(input exps_t exps, input logic [3:0] din);
    logic [1:0] e;
    e = 2'd0;
    case (din)
      DIN_P2:  e = exps.e2;
      DIN_P3:  e = exps.e3;
      DIN_P5:  e = exps.e5;
      DIN_P7:  e = exps.e7;
      default: e = 2'd0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/factor_qrom.sv
// Question ROM: maps a question index to its prime exponents {e2,e3,e5,e7}.
// Latency: combinational.
// Backpressure: none.
// Ports: que (question index 0..9), exps (exponents; all zero for an index >= 10).
module factor_qrom
  import factor_pkg::*;
(
  input  logic [3:0] que,
  output exps_t      exps
);

  always_comb begin
    exps = '0;
    if (que < 4'(NUM_Q)) begin
      exps = Q_TABLE[que];
    end
  end

endmodule

// File: rtl/factor_game_ctrl.sv
// Factor game controller: player factors a displayed number by repeatedly submitting primes.
// Latency: all outputs registered, changing one cycle after the causing button/timer event.
// Backpressure: none; buttons are one-cycle pulses and are dropped when not accepted.
// Ports: CLK, nRST (async active-low); BTN_START/BTN_SEL/BTN_OK debounced pulses;
//        STATE game state code, DIN selected prime (0 none, 1..4 = 2,3,5,7),
//        QUE question index, MISS misses in the current game.
module factor_game_ctrl
  import factor_pkg::*;
#(
  parameter int SHOW_CYC    = 25_000_000,
  parameter int TIMEOUT_CYC = 250_000_000,
  parameter int MAX_MISS    = 3
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       BTN_START,
  input  logic       BTN_SEL,
  input  logic       BTN_OK,
  output logic [3:0] STATE,
  output logic [3:0] DIN,
  output logic [3:0] QUE,
  output logic [1:0] MISS
);

  localparam int TMAX = (SHOW_CYC > TIMEOUT_CYC) ? SHOW_CYC : TIMEOUT_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    MISS_LIMIT   = 3'(MAX_MISS);

  state_t          state_q, state_d;
  logic [3:0]      din_q, din_d;
  logic [3:0]      que_q, que_d;
  logic [1:0]      miss_q, miss_d;
  exps_t           exps_q, exps_d;
  exps_t           exps_dec;
  exps_t           rom_exps;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      cnt10_q;

  logic [1:0]      sel_exp;
  logic [2:0]      miss_sum;
  logic            show_done;
  logic            timeout;
  logic            hit;
  logic            last_miss;
  logic            solved;

  // The ROM is addressed by the free-running counter because that value becomes
  // QUE on the same edge that loads the exponents.
  factor_qrom u_qrom (
    .que  (cnt10_q),
    .exps (rom_exps)
  );

  assign show_done = (timer_q == SHOW_LAST);
  assign timeout   = (timer_q == TIMEOUT_LAST);
  assign sel_exp   = exp_of(exps_q, din_q);
  assign hit       = (sel_exp != 2'd0);
  assign miss_sum  = {1'b0, miss_q} + 3'd1;
  assign last_miss = (miss_sum == MISS_LIMIT);
  assign solved    = (exps_dec == '0);

  // Exponents after consuming one factor of the selected prime.
  always_comb begin
    exps_dec = exps_q;
    case (din_q)
      DIN_P2:  exps_dec.e2 = exps_q.e2 - 2'd1;
      DIN_P3:  exps_dec.e3 = exps_q.e3 - 2'd1;
      DIN_P5:  exps_dec.e5 = exps_q.e5 - 2'd1;
      DIN_P7:  exps_dec.e7 = exps_q.e7 - 2'd1;
      default: exps_dec = exps_q;
    endcase
  end

  // ---------------------------------------------------------------- state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_READY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  // In INPUT a submit always wins over the timeout on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY: begin
        if (BTN_START) state_d = ST_QUESTION;
      end
      ST_QUESTION: begin
        if (show_done) state_d = ST_INPUT;
      end
      ST_INPUT: begin
        if (BTN_OK) begin
          if (hit) state_d = solved ? ST_WIN : ST_GOOD;
          else     state_d = last_miss ? ST_LOSE : ST_WRONG;
        end else if (timeout) begin
          state_d = last_miss ? ST_LOSE : ST_OUCH;
        end
      end
      ST_GOOD, ST_WRONG, ST_OUCH: begin
        if (show_done) state_d = ST_INPUT;
      end
      ST_WIN, ST_LOSE: begin
        if (BTN_START) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  // ---------------------------------------------------------------- output/datapath next values
  always_comb begin
    din_d  = din_q;
    que_d  = que_q;
    miss_d = miss_q;
    exps_d = exps_q;
    case (state_q)
      ST_READY: begin
        if (BTN_START) begin
          que_d  = cnt10_q;
          exps_d = rom_exps;
          miss_d = 2'd0;
        end
      end
      ST_QUESTION: begin
        if (show_done) din_d = DIN_P2;
      end
      ST_INPUT: begin
        // A submit consumes the current selection; a simultaneous SEL is dropped.
        if (BTN_OK) begin
          if (hit) exps_d = exps_dec;
          else     miss_d = miss_sum[1:0];
        end else if (timeout) begin
          miss_d = miss_sum[1:0];
        end else if (BTN_SEL) begin
          din_d = (din_q == DIN_P7) ? DIN_P2 : din_q + 4'd1;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (BTN_START) din_d = DIN_NONE;
      end
      default: begin
        din_d = din_q;
      end
    endcase

    // One shared timer: restarts on any state change, saturates instead of wrapping.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      din_q   <= DIN_NONE;
      que_q   <= 4'd0;
      miss_q  <= 2'd0;
      exps_q  <= '0;
      timer_q <= '0;
      cnt10_q <= 4'd0;
    end else begin
      din_q   <= din_d;
      que_q   <= que_d;
      miss_q  <= miss_d;
      exps_q  <= exps_d;
      timer_q <= timer_d;
      cnt10_q <= (cnt10_q == 4'd9) ? 4'd0 : cnt10_q + 4'd1;
    end
  end

  assign STATE = state_q;
  assign DIN   = din_q;
  assign QUE   = que_q;
  assign MISS  = miss_q;

endmodule

// File: tb/tb_factor_game_ctrl.sv
// Scoreboard bench for factor_game_ctrl with short timers (SHOW 4, TIMEOUT 20, MAX_MISS 3).
// Stimulus pushes every expected output change with the cycle it must appear on;
// a monitor pops an entry whenever the DUT outputs change and compares value and timing.
module tb_factor_game_ctrl;

  localparam int SHOW = 4;
  localparam int TO   = 20;
  localparam int MAXM = 3;

  localparam logic [3:0] S_READY = 4'b0010;
  localparam logic [3:0] S_QUEST = 4'b0011;
  localparam logic [3:0] S_INPUT = 4'b0100;
  localparam logic [3:0] S_WRONG = 4'b0111;
  localparam logic [3:0] S_GOOD  = 4'b1000;
  localparam logic [3:0] S_OUCH  = 4'b1001;
  localparam logic [3:0] S_WIN   = 4'b1010;
  localparam logic [3:0] S_LOSE  = 4'b1011;

  logic       CLK = 1'b0;
  logic       nRST = 1'b1;
  logic       BTN_START = 1'b0;
  logic       BTN_SEL = 1'b0;
  logic       BTN_OK = 1'b0;
  logic [3:0] STATE, DIN, QUE;
  logic [1:0] MISS;

  factor_game_ctrl #(
    .SHOW_CYC    (SHOW),
    .TIMEOUT_CYC (TO),
    .MAX_MISS    (MAXM)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .BTN_START (BTN_START),
    .BTN_SEL   (BTN_SEL),
    .BTN_OK    (BTN_OK),
    .STATE     (STATE),
    .DIN       (DIN),
    .QUE       (QUE),
    .MISS      (MISS)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc;

  // Cycles since reset release; cyc % 10 is the value the game's question counter must hold.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  din;
    logic [3:0]  que;
    logic [1:0]  miss;
    logic [31:0] at;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] last_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every change of {STATE,DIN,QUE,MISS} must match the next queued expectation.
  always @(negedge CLK) begin : monitor
    logic [13:0] cur;
    exp_t        e;
    cur = {STATE, DIN, QUE, MISS};
    if (!nRST) begin
      last_out = cur;
    end else if (cur !== last_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: got state=%h din=%0d que=%0d miss=%0d, want no change (cycle %0d)",
                 STATE, DIN, QUE, MISS, cyc);
      end else begin
        e = sb.pop_front();
        chk("outputs{st,din,que,miss}", 32'(cur), 32'({e.st, e.din, e.que, e.miss}));
        chk("change_cycle", cyc, e.at);
      end
      last_out = cur;
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic expect_at(input logic [3:0] st, input logic [3:0] din, input logic [3:0] que,
                           input logic [1:0] miss, input int dly);
    exp_t e;
    e.st   = st;
    e.din  = din;
    e.que  = que;
    e.miss = miss;
    e.at   = 32'(cyc + dly);
    sb.push_back(e);
  endtask

  task automatic press(input logic s, input logic l, input logic o);
    BTN_START = s;
    BTN_SEL   = l;
    BTN_OK    = o;
    step();
    BTN_START = 1'b0;
    BTN_SEL   = 1'b0;
    BTN_OK    = 1'b0;
  endtask

  // Press buttons and expect the given outputs on the very next cycle.
  task automatic act(input logic s, input logic l, input logic o,
                     input logic [3:0] st, input logic [3:0] din, input logic [3:0] que,
                     input logic [1:0] miss);
    expect_at(st, din, que, miss, 1);
    press(s, l, o);
  endtask

  // Wait (bounded) until every queued expectation has been observed.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending changes, want 0 (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  // From READY: wait until the question counter equals k, start, reach INPUT with DIN=1.
  task automatic start_at(input logic [3:0] k);
    int n;
    n = 0;
    while ((cyc % 10) != int'(k) && n < 20) begin
      step();
      n++;
    end
    act(1'b1, 1'b0, 1'b0, S_QUEST, 4'd0, k, 2'd0);
    expect_at(S_INPUT, 4'd1, k, 2'd0, SHOW);
    drain();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(STATE), 32'(S_READY));
    chk({tag, "_din"},   32'(DIN),   32'd0);
    chk({tag, "_que"},   32'(QUE),   32'd0);
    chk({tag, "_miss"},  32'(MISS),  32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

  int t0;

  initial begin : stim
    #2 nRST = 1'b0;
    #1 chk_reset_outputs("por");
    step();
    step();
    nRST = 1'b1;

    // Game A: Q=12 (2,1,0,0): OK,OK on prime 2 then SEL, OK on prime 3 -> WIN.
    start_at(4'd0);
    act(1'b0, 1'b0, 1'b1, S_GOOD, 4'd1, 4'd0, 2'd0);
    expect_at(S_INPUT, 4'd1, 4'd0, 2'd0, SHOW);
    drain();
    act(1'b0, 1'b0, 1'b1, S_GOOD, 4'd1, 4'd0, 2'd0);
    expect_at(S_INPUT, 4'd1, 4'd0, 2'd0, SHOW);
    drain();
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd2, 4'd0, 2'd0);
    drain();
    act(1'b0, 1'b0, 1'b1, S_WIN, 4'd2, 4'd0, 2'd0);
    drain();
    // WIN holds past any timer length; SEL/OK ignored.
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    repeat (30) step();
    act(1'b1, 1'b0, 1'b0, S_READY, 4'd0, 4'd0, 2'd0);
    drain();

    // Game B: Q=12, prime 5 three times -> WRONG, WRONG, LOSE.
    start_at(4'd0);
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd2, 4'd0, 2'd0);
    drain();
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd3, 4'd0, 2'd0);
    drain();
    act(1'b0, 1'b0, 1'b1, S_WRONG, 4'd3, 4'd0, 2'd1);
    expect_at(S_INPUT, 4'd3, 4'd0, 2'd1, SHOW);
    drain();
    act(1'b0, 1'b0, 1'b1, S_WRONG, 4'd3, 4'd0, 2'd2);
    expect_at(S_INPUT, 4'd3, 4'd0, 2'd2, SHOW);
    drain();
    act(1'b0, 1'b0, 1'b1, S_LOSE, 4'd3, 4'd0, 2'd3);
    drain();
    press(1'b0, 1'b0, 1'b1);
    repeat (5) step();
    act(1'b1, 1'b0, 1'b0, S_READY, 4'd0, 4'd0, 2'd3);
    drain();

    // Game C: Q=42 (1,1,0,1): idle timeout, OK on the timeout cycle, OK+SEL miss, timeout loss.
    start_at(4'd3);
    expect_at(S_OUCH,  4'd1, 4'd3, 2'd1, TO);
    expect_at(S_INPUT, 4'd1, 4'd3, 2'd1, TO + SHOW);
    drain();
    t0 = cyc;
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd2, 4'd3, 2'd1);
    drain();
    while (cyc < t0 + TO - 1) step();
    act(1'b0, 1'b0, 1'b1, S_GOOD, 4'd2, 4'd3, 2'd1);
    expect_at(S_INPUT, 4'd2, 4'd3, 2'd1, SHOW);
    drain();
    act(1'b0, 1'b1, 1'b1, S_WRONG, 4'd2, 4'd3, 2'd2);
    expect_at(S_INPUT, 4'd2, 4'd3, 2'd2, SHOW);
    drain();
    expect_at(S_LOSE, 4'd2, 4'd3, 2'd3, TO);
    drain();
    act(1'b1, 1'b0, 1'b0, S_READY, 4'd0, 4'd3, 2'd3);
    drain();

    // Game D: Q=12, OK+SEL with DIN=1 -> GOOD, DIN stays 1, e2 2->1; START ignored in INPUT.
    start_at(4'd0);
    act(1'b0, 1'b1, 1'b1, S_GOOD, 4'd1, 4'd0, 2'd0);
    expect_at(S_INPUT, 4'd1, 4'd0, 2'd0, SHOW);
    drain();
    press(1'b1, 1'b0, 1'b0);
    repeat (3) step();
    act(1'b0, 1'b0, 1'b1, S_GOOD, 4'd1, 4'd0, 2'd0);
    expect_at(S_INPUT, 4'd1, 4'd0, 2'd0, SHOW);
    drain();

    // Asynchronous reset in the middle of INPUT, checked before any clock edge.
    nRST = 1'b0;
    #1 chk_reset_outputs("midgame_rst");
    step();
    step();
    nRST = 1'b1;

    // Game E: Q=70 (1,0,1,1): DIN wraps 4->1, then solve with one miss -> WIN.
    start_at(4'd5);
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd2, 4'd5, 2'd0);
    drain();
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd3, 4'd5, 2'd0);
    drain();
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd4, 4'd5, 2'd0);
    drain();
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd1, 4'd5, 2'd0);
    drain();
    act(1'b0, 1'b0, 1'b1, S_GOOD, 4'd1, 4'd5, 2'd0);
    expect_at(S_INPUT, 4'd1, 4'd5, 2'd0, SHOW);
    drain();
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd2, 4'd5, 2'd0);
    drain();
    act(1'b0, 1'b0, 1'b1, S_WRONG, 4'd2, 4'd5, 2'd1);
    expect_at(S_INPUT, 4'd2, 4'd5, 2'd1, SHOW);
    drain();
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd3, 4'd5, 2'd1);
    drain();
    act(1'b0, 1'b0, 1'b1, S_GOOD, 4'd3, 4'd5, 2'd1);
    expect_at(S_INPUT, 4'd3, 4'd5, 2'd1, SHOW);
    drain();
    act(1'b0, 1'b1, 1'b0, S_INPUT, 4'd4, 4'd5, 2'd1);
    drain();
    act(1'b0, 1'b0, 1'b1, S_WIN, 4'd4, 4'd5, 2'd1);
    drain();
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/factor_game_ctrl.md
FACTOR_GAME_CTRL -- requirements
Module: factor_game_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYC, 25_000_000, cycles spent in QUESTION/GOOD/WRONG/OUCH before advancing.
REQ-002 SHALL have parameter TIMEOUT_CYC, 250_000_000, INPUT cycles without BTN_OK before a timeout miss.
REQ-003 SHALL have parameter MAX_MISS, 3, misses that end the game in LOSE.
REQ-004 SHALL use one clock and an asynchronous active-low reset: CLK  in  1  rising-edge clock; nRST  in  1  async active-low reset.
REQ-005 SHALL have BTN_START  in  1  debounced one-cycle pulse, start/restart.
REQ-006 SHALL have BTN_SEL  in  1  debounced one-cycle pulse, advance prime selection.
REQ-007 SHALL have BTN_OK  in  1  debounced one-cycle pulse, submit selection.
REQ-008 SHALL have STATE  out  4  game state code, feeds the 7-segment decoder.
REQ-009 SHALL have DIN  out  4  selected prime index: 0 none, 1..4 = primes 2,3,5,7.
REQ-010 SHALL have QUE  out  4  current question index 0..9.
REQ-011 SHALL have MISS  out  2  misses so far in current game.

Function
REQ-012 SHALL encode states READY 0010, QUESTION 0011, INPUT 0100, WRONG 0111, GOOD 1000, OUCH 1001, WIN 1010, LOSE 1011; no other code is ever driven.
REQ-013 SHALL register all outputs; output changes appear one cycle after the causing input/timer event.
REQ-014 SHALL run a free-running mod-10 counter (0..9, wraps 9->0) every cycle from reset.
REQ-015 SHALL hold a question as 2-bit exponents (e2,e3,e5,e7): 0:12(2,1,0,0) 1:18(1,2,0,0) 2:30(1,1,1,0) 3:42(1,1,0,1) 4:60(2,1,1,0) 5:70(1,0,1,1) 6:84(2,1,0,1) 7:90(1,2,1,0) 8:105(0,1,1,1) 9:126(1,2,0,1).
REQ-016 READY: BTN_START -> QUESTION; QUE <= mod-10 counter; exponents loaded from table; MISS <= 0; timer cleared.
REQ-017 QUESTION: after SHOW_CYC cycles -> INPUT; DIN <= 1; timer cleared.
REQ-018 INPUT: BTN_SEL cycles DIN 1->2->3->4->1; DIN never 0 in INPUT.
REQ-019 INPUT, BTN_OK with selected exponent nonzero: decrement it; all exponents zero afterwards -> WIN, else GOOD.
REQ-020 INPUT, BTN_OK with selected exponent zero: MISS+1; MISS+1 == MAX_MISS -> LOSE, else WRONG.
REQ-021 INPUT, timer reaches TIMEOUT_CYC-1 without BTN_OK: MISS+1; -> LOSE if MAX_MISS reached, else OUCH.
REQ-022 Simultaneous events in INPUT: BTN_OK beats timeout; BTN_OK beats BTN_SEL (current DIN evaluated, SEL dropped).
REQ-023 GOOD/WRONG/OUCH: after SHOW_CYC cycles -> INPUT, DIN retained, timer cleared; buttons ignored.
REQ-024 WIN/LOSE: held indefinitely; BTN_START -> READY, DIN <= 0; other buttons ignored.
REQ-025 BTN_START SHALL be ignored outside READY/WIN/LOSE; BTN_SEL/BTN_OK ignored outside INPUT.
REQ-026 Single shared timer, width ceil(log2(max(SHOW_CYC,TIMEOUT_CYC))), cleared on every state change, never wraps.

Reset
REQ-027 nRST low SHALL asynchronously force STATE=0010 (READY), DIN=0, QUE=0, MISS=0, exponents 0, timer 0, mod-10 counter 0.
REQ-028 Reset mid-game SHALL abandon the game entirely; first post-release edge behaves as READY.

Structure
REQ-029 State encodings and the 10-entry exponent table SHALL live in shared package factor_pkg, also used by the display decoder.
REQ-030 SHALL instantiate one sub-module, factor_qrom: combinational QUE -> {e2,e3,e5,e7} lookup.

Verification (SHOW_CYC=4, TIMEOUT_CYC=20, MAX_MISS=3)
REQ-031 nRST low mid-INPUT -> STATE=0010, DIN=0, QUE=0, MISS=0 immediately, without a clock edge.
REQ-032 START with counter=0 (Q=12); after 4 cycles DIN=1; OK,OK,SEL,OK -> GOOD,GOOD,WIN sequence, STATE=1010.
REQ-033 Q=12, DIN=3 (prime 5), OK three times -> WRONG, WRONG, LOSE; MISS=1,2,3; STATE=1011.
REQ-034 INPUT idle 20 cycles -> STATE=1001, MISS=1; after 4 cycles STATE=0100, DIN unchanged.
REQ-035 BTN_OK and BTN_SEL same cycle, DIN=1, Q=12 -> GOOD, DIN stays 1, e2 2->1.
REQ-036 BTN_OK on the timeout cycle -> evaluated as OK (GOOD/WRONG), not OUCH.
